// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: handshaked multi-cycle adder/subtractor.
// Adds CHUNK bits per clock with a registered inter-chunk carry.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             D,
  output logic             V
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic             carry_q;
  logic             sub_q;
  logic             d_q;
  logic             v_q;
  logic [KW-1:0]    k;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   sum;
  logic             msb_cin;
  logic             accept;
  logic             last;
  logic             release_q;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign release_q = out_valid & out_ready;
  assign last      = (k == K_LAST);

  // A and B' shift right so the active slice is always the low CHUNK bits.
  assign a_sl = a_q[CHUNK-1:0];
  assign b_sl = b_q[CHUNK-1:0];

  // One CHUNK+1 bit slice adder; the top bit is the slice carry-out.
  assign sum = {1'b0, a_sl} + {1'b0, b_sl}
             + {{CHUNK{1'b0}}, carry_q};

  // Carry into the slice MSB, recovered from the MSB sum bit.
  assign msb_cin = sum[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = RUN;
      RUN:  if (last) state_nx = DONE;
      DONE: if (release_q) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, slice iteration and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      d_q     <= 1'b0;
      v_q     <= 1'b0;
      k       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= A;
            b_q     <= SUB ? ~B : B;
            carry_q <= SUB ? ~C : C;
            sub_q   <= SUB;
            s_q     <= '0;
            d_q     <= 1'b0;
            v_q     <= 1'b0;
            k       <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
              s_q[i*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
            end
          end
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          carry_q <= sum[CHUNK];
          k       <= k + 1'b1;
          if (last) begin
            d_q <= sum[CHUNK] ^ sub_q;
            v_q <= msb_cin ^ sum[CHUNK];
            k   <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign S = s_q;
  assign D = d_q;
  assign V = v_q;

endmodule
